// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/logic/concat/accumulate/clear ops plus an
// N-cycle unsigned shift-add multiply. All outputs come straight from flops.
module seq_alu #(
    parameter int N = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Function,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic [2*N-1:0]   ALUout,
    output logic             Busy,
    output logic             Done
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] FN_ADD   = 3'd0;
    localparam logic [2:0] FN_OR    = 3'd1;
    localparam logic [2:0] FN_AND   = 3'd2;
    localparam logic [2:0] FN_CAT   = 3'd3;
    localparam logic [2:0] FN_ACC   = 3'd4;
    localparam logic [2:0] FN_MUL   = 3'd5;
    localparam logic [2:0] FN_CLR   = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    alu_q, alu_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic [W-1:0]    pp_q, pp_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    pp_sum;

    always_comb begin
        state_d  = state_q;
        alu_d    = alu_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        pp_d     = pp_q;
        count_d  = count_q;
        pp_sum   = pp_q + (mplier_q[0] ? mcand_q : '0);

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    done_d = (Function != FN_MUL);
                    case (Function)
                        FN_ADD: alu_d = W'(A) + W'(B);
                        FN_OR:  alu_d = W'(|{A, B});
                        FN_AND: alu_d = W'(&{A, B});
                        FN_CAT: alu_d = {A, B};
                        FN_ACC: alu_d = alu_q + W'(A);
                        FN_MUL: begin
                            state_d  = MUL;
                            mcand_d  = W'(A);
                            mplier_d = B;
                            pp_d     = '0;
                            count_d  = '0;
                        end
                        FN_CLR: alu_d = '0;
                        default: alu_d = alu_q;
                    endcase
                end
            end
            MUL: begin
                // Fixed N iterations regardless of operand values, so latency never varies.
                pp_d     = pp_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    alu_d   = pp_sum;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == MUL);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            alu_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            pp_q     <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            alu_q    <= alu_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            pp_q     <= pp_d;
            count_q  <= count_d;
        end
    end

    assign ALUout = alu_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (N=4): expected results are queued at accept
// and popped when Done is observed.
module tb_seq_alu;

    localparam int N = 4;

    logic           Clock = 1'b0;
    logic           Reset;
    logic           Start;
    logic [2:0]     Function;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [2*N-1:0] ALUout;
    logic           Busy;
    logic           Done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model = 8'h00;

    seq_alu #(.N(N)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Function (Function),
        .A        (A),
        .B        (B),
        .ALUout   (ALUout),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_op(input logic [2:0] f, input logic [3:0] a,
                                          input logic [3:0] b, input logic [7:0] cur);
        logic [7:0] r;
        case (f)
            3'd0: r = {4'b0, a} + {4'b0, b};
            3'd1: r = {7'b0, |{a, b}};
            3'd2: r = {7'b0, &{a, b}};
            3'd3: r = {a, b};
            3'd4: r = cur + {4'b0, a};
            3'd5: r = {4'b0, a} * {4'b0, b};
            3'd6: r = 8'h00;
            default: r = cur;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Function = 3'd0; A = '0; B = '0;
        step();
        step();
        Reset = 1'b0;
        model = 8'h00;
        checks++;
        if (ALUout !== 8'h00) begin
            errors++; $display("FAIL reset_aluout: got %h required 00", ALUout);
        end
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL reset_flags: Busy=%b Done=%b required 0 0", Busy, Done);
        end
    endtask

    task automatic test_single_op(input logic [2:0] f, input logic [3:0] a,
                                  input logic [3:0] b, input string name);
        logic [7:0] exp;
        logic [7:0] got;
        Function = f; A = a; B = b; Start = 1'b1;
        exp = ref_op(f, a, b, model);
        model = exp;
        exp_q.push_back(exp);
        step();
        Start = 1'b0;
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0) begin
            errors++; $display("FAIL %s_handshake: Done=%b Busy=%b required Done=1 Busy=0", name, Done, Busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s_result: scoreboard empty, got %h", name, ALUout);
        end else begin
            got = exp_q.pop_front();
            if (ALUout !== got) begin
                errors++; $display("FAIL %s_result: got %h required %h", name, ALUout, got);
            end
        end
        step();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL %s_after: Done=%b Busy=%b required 0 0", name, Done, Busy);
        end
    endtask

    task automatic test_add();
        test_single_op(3'd0, 4'd15, 4'd15, "add_15_15");
        test_single_op(3'd0, 4'd3, 4'd9, "add_3_9");
    endtask

    task automatic test_multiply();
        logic [7:0] old;
        logic [7:0] got;
        old = model;
        Function = 3'd5; A = 4'd13; B = 4'd11; Start = 1'b1;
        exp_q.push_back(ref_op(3'd5, 4'd13, 4'd11, model));
        model = ref_op(3'd5, 4'd13, 4'd11, model);
        step();
        for (int k = 0; k < N; k++) begin
            checks++;
            if (Busy !== 1'b1 || Done !== 1'b0 || ALUout !== old) begin
                errors++;
                $display("FAIL mul_busy_%0d: Busy=%b Done=%b ALUout=%h required 1 0 %h", k, Busy, Done, ALUout, old);
            end
            A = 4'($urandom); B = 4'($urandom); Function = 3'($urandom);
            Start = 1'b1;
            step();
        end
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b1) begin
            errors++; $display("FAIL mul_done: Busy=%b Done=%b required 0 1", Busy, Done);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL mul_result: scoreboard empty, got %h", ALUout);
        end else begin
            got = exp_q.pop_front();
            if (ALUout !== got) begin
                errors++; $display("FAIL mul_result: got %h required %h", ALUout, got);
            end
        end
        step();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || ALUout !== 8'h8F) begin
            errors++; $display("FAIL mul_no_second: Busy=%b Done=%b ALUout=%h required 0 0 8f", Busy, Done, ALUout);
        end
    endtask

    task automatic test_accumulate();
        test_single_op(3'd6, 4'd0, 4'd0, "clear");
        for (int i = 0; i < 17; i++) test_single_op(3'd4, 4'd15, 4'd0, "acc");
        checks++;
        if (ALUout !== 8'hFF) begin
            errors++; $display("FAIL acc_17: got %h required ff", ALUout);
        end
        test_single_op(3'd4, 4'd15, 4'd0, "acc_wrap");
        checks++;
        if (ALUout !== 8'h0E) begin
            errors++; $display("FAIL acc_wrap_value: got %h required 0e", ALUout);
        end
    endtask

    task automatic test_reset_mid_mul();
        Function = 3'd5; A = 4'd7; B = 4'd9; Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        checks++;
        if (Busy !== 1'b1) begin
            errors++; $display("FAIL abort_busy: Busy=%b required 1", Busy);
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        model = 8'h00;
        checks++;
        if (ALUout !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL abort_state: ALUout=%h Busy=%b Done=%b required 00 0 0", ALUout, Busy, Done);
        end
        for (int k = 0; k < N + 1; k++) begin
            step();
            checks++;
            if (Done !== 1'b0 || Busy !== 1'b0 || ALUout !== 8'h00) begin
                errors++; $display("FAIL abort_quiet_%0d: Done=%b Busy=%b ALUout=%h required 0 0 00", k, Done, Busy, ALUout);
            end
        end
    endtask

    task automatic test_reset_priority();
        test_single_op(3'd0, 4'd1, 4'd2, "pre_prio");
        Reset = 1'b1; Start = 1'b1; Function = 3'd3; A = 4'hA; B = 4'h5;
        step();
        Reset = 1'b0; Start = 1'b0;
        model = 8'h00;
        checks++;
        if (ALUout !== 8'h00 || Done !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL reset_priority: ALUout=%h Done=%b Busy=%b required 00 0 0", ALUout, Done, Busy);
        end
        step();
        checks++;
        if (Done !== 1'b0 || ALUout !== 8'h00) begin
            errors++; $display("FAIL reset_priority_after: Done=%b ALUout=%h required 0 00", Done, ALUout);
        end
    endtask

    task automatic test_logic();
        test_single_op(3'd3, 4'hA, 4'h5, "cat");
        test_single_op(3'd7, 4'h3, 4'hC, "nop_a5");
        test_single_op(3'd2, 4'hA, 4'h5, "and_a5");
        test_single_op(3'd2, 4'hF, 4'hF, "and_ff");
        test_single_op(3'd1, 4'h0, 4'h0, "or_00");
        test_single_op(3'd1, 4'h0, 4'h1, "or_01");
        test_single_op(3'd7, 4'h0, 4'h0, "nop_01");
        checks++;
        if (ALUout !== 8'h01) begin
            errors++; $display("FAIL nop_hold: got %h required 01", ALUout);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        Function = 3'd5; A = 4'd15; B = 4'd15; Start = 1'b1;
        model = ref_op(3'd5, 4'd15, 4'd15, model);
        exp_q.push_back(model);
        step();
        Start = 1'b0;
        for (int k = 0; k < N; k++) step();
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0) begin
            errors++; $display("FAIL b2b_mul_done: Done=%b Busy=%b required 1 0", Done, Busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL b2b_mul_result: scoreboard empty, got %h", ALUout);
        end else begin
            got = exp_q.pop_front();
            if (ALUout !== got) begin
                errors++; $display("FAIL b2b_mul_result: got %h required %h", ALUout, got);
            end
        end
        Function = 3'd4; A = 4'd3; B = 4'd0; Start = 1'b1;
        model = ref_op(3'd4, 4'd3, 4'd0, model);
        exp_q.push_back(model);
        step();
        Function = 3'd0; A = 4'd6; B = 4'd7;
        model = ref_op(3'd0, 4'd6, 4'd7, model);
        exp_q.push_back(model);
        checks++;
        if (Done !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL b2b_acc: Done=%b ALUout=%h required Done=1", Done, ALUout);
        end else begin
            got = exp_q.pop_front();
            if (ALUout !== got) begin
                errors++; $display("FAIL b2b_acc: got %h required %h", ALUout, got);
            end
        end
        step();
        Start = 1'b0;
        checks++;
        if (Done !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL b2b_add: Done=%b ALUout=%h required Done=1", Done, ALUout);
        end else begin
            got = exp_q.pop_front();
            if (ALUout !== got) begin
                errors++; $display("FAIL b2b_add: got %h required %h", ALUout, got);
            end
        end
        step();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: Done=%b Busy=%b required 0 0", Done, Busy);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_multiply();
        test_accumulate();
        test_reset_mid_mul();
        test_reset_priority();
        test_logic();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL take parameter: N, default 4, operand width in bits (legal N >= 2).
REQ-002 The block SHALL have port: Clock  input  1  rising-edge clock.
REQ-003 The block SHALL have port: Reset  input  1  synchronous active-high reset.
REQ-004 The block SHALL have port: Start  input  1  operation request, sampled on Clock rising edge.
REQ-005 The block SHALL have port: Function  input  3  operation select, captured on accept.
REQ-006 The block SHALL have port: A  input  N  operand A, captured on accept.
REQ-007 The block SHALL have port: B  input  N  operand B, captured on accept.
REQ-008 The block SHALL have port: ALUout  output  2N  registered result.
REQ-009 The block SHALL have port: Busy  output  1  high while a multi-cycle operation is in progress.
REQ-010 The block SHALL have port: Done  output  1  one-cycle pulse on result write or completion.

Function
REQ-011 The block SHALL run on one clock, Clock, with Reset synchronous and active-high; all outputs SHALL be registered.
REQ-012 Accept SHALL occur on a rising edge where Start=1, Busy=0 and Reset=0; Start while Busy=1 SHALL be ignored, with no queuing.
REQ-013 Function codes SHALL be as follows:
- 0: ALUout = A+B, zero-extended, carry in bit N.
- 1: ALUout = {0..., |{A,B}}.
- 2: ALUout = {0..., &{A,B}}.
- 3: ALUout = {A,B}, A in upper half.
- 4: ALUout = ALUout + zero-extended A, modulo 2^(2N) (accumulate).
- 5: ALUout = A*B, unsigned, multi-cycle.
- 6: ALUout = 0.
- 7: no change.
REQ-014 Codes 0-4, 6 and 7 SHALL be single-cycle: ALUout updates on the accept edge, Done=1 for exactly the following cycle, and Busy stays 0.
REQ-015 The state machine SHALL have states IDLE and MUL: IDLE->MUL on accept with Function=5; MUL->IDLE on the Nth edge after accept; Reset forces IDLE from any state.
REQ-016 The multiply SHALL be shift-add: the accept edge loads multiplicand (2N bits), multiplier (N bits), partial product=0 and count=0; each of the next N edges adds the multiplicand if multiplier[0]=1, shifts the multiplicand left 1 and the multiplier right 1, and increments count.
REQ-017 Multiply latency SHALL be exactly N edges after accept, independent of operand values (0 operands included); ALUout SHALL be written on the Nth edge.
REQ-018 Busy SHALL be 1 from the cycle after accept through the cycle containing the Nth edge, and SHALL fall after that edge; Done SHALL pulse in the same cycle Busy falls.
REQ-019 During MUL, ALUout SHALL hold its pre-accept value, and changes on A, B, Function or Start SHALL have no effect.
REQ-020 A new accept SHALL be allowed on the edge at which Done=1 is visible, so back-to-back operations run with no idle cycle.
REQ-021 Accumulate overflow SHALL wrap silently, with no flag.
REQ-022 All arithmetic SHALL be unsigned; the product of two N-bit values SHALL fit in 2N bits without truncation.

Reset
REQ-023 When Reset=1 at a rising edge, ALUout=0, Busy=0, Done=0, state=IDLE, and all multiply registers and count SHALL be 0.
REQ-024 Reset SHALL take priority over Start on the same edge; no operation is accepted.
REQ-025 Reset mid-multiply SHALL abort the operation: no Done pulse, and ALUout=0.

Verification
REQ-026 The bench SHALL cover all of the following scenarios, with N=4:
- Assert Reset one edge -> ALUout=0x00, Busy=0, Done=0.
- Function=0, A=15, B=15, Start one cycle -> ALUout=0x1E next cycle, Done high one cycle, Busy never 1.
- Function=5, A=13, B=11, Start, then Start held high and A/B toggled -> Busy high 4 cycles, ALUout holds the old value, then 0x8F, single Done pulse, no second operation accepted.
- Function=6, then Function=4 with A=15 seventeen times -> ALUout=0xFF; one more -> 0x0E (wrap).
- Function=5 accepted, Reset asserted on the 2nd Busy cycle -> ALUout=0x00, Busy=0, no Done.
- A=0xA, B=0x5: Function=3 -> 0xA5; Function=2 -> 0x00; A=B=15, Function=2 -> 0x01; A=B=0, Function=1 -> 0x00; Function=7 -> unchanged, Done pulses.
